// File: rtl/uarttx_fifo_if.sv
// Producer-side write port of the FIFO-backed UART transmitter: character
// strobe in, occupancy and overflow status out.
interface uarttx_fifo_if #(
    parameter int DataBits  = 8,
    parameter int FifoDepth = 16
);
    logic [DataBits-1:0]              wr_data;
    logic                             wr_en;
    logic                             full;
    logic                             empty;
    logic [$clog2(FifoDepth+1)-1:0]   count;
    logic                             overflow;

    modport master (
        output wr_data, wr_en,
        input  full, empty, count, overflow
    );

    modport slave (
        input  wr_data, wr_en,
        output full, empty, count, overflow
    );
endinterface

// File: rtl/uarttx_fifo.sv
// UART transmitter with a circular transmit FIFO. Characters are popped into
// a shift register at frame start, so the frame in flight is independent of
// later FIFO activity. Frames run back-to-back while the FIFO holds data.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | line high, waiting for the FIFO to become non-empty
// S_START  | start bit (0) for one bit time
// S_DATA   | DataBits data bits, LSB first
// S_PARITY | parity bit (only when ParityMode != 0)
// S_STOP   | StopBits stop bits (1); pops the next character if any
module uarttx_fifo #(
    parameter int ClockFrequencyHz = 66_000_000,
    parameter int BaudRate         = 9600,
    parameter int DataBits         = 8,
    parameter int ParityMode       = 0,
    parameter int StopBits         = 1,
    parameter int FifoDepth        = 16
) (
    input  logic          clk,
    input  logic          rst,
    uarttx_fifo_if.slave  bus,
    output logic          tx,
    output logic          bsy
);
    localparam int BitTime = ClockFrequencyHz / BaudRate;
    localparam int CntW    = (BitTime > 1) ? $clog2(BitTime) : 1;
    localparam int PtrW    = $clog2(FifoDepth);
    localparam int CountW  = $clog2(FifoDepth + 1);

    localparam logic [CntW-1:0] BitReload = CntW'(BitTime - 1);
    localparam logic [3:0]      LastData  = 4'(DataBits - 1);
    localparam logic [3:0]      LastStop  = 4'(StopBits - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [DataBits-1:0] mem [FifoDepth];
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CountW-1:0]   count_q;
    logic                overflow_q;
    logic                full_w, empty_w, push, pop;
    logic [DataBits-1:0] head;
    logic [CntW-1:0]     bit_cnt_q;
    logic                bit_done;
    logic [3:0]          bit_idx_q;
    logic                last_data, last_stop;
    logic [DataBits-1:0] shift_q;
    logic                parity_q;
    logic                tx_q;
    logic                line_lvl;

    assign full_w    = (count_q == CountW'(FifoDepth));
    assign empty_w   = (count_q == '0);
    assign push      = bus.wr_en && !full_w;
    assign head      = mem[rd_ptr_q];
    assign bit_done  = (bit_cnt_q == '0);
    assign last_data = (bit_idx_q == LastData);
    assign last_stop = (bit_idx_q == LastStop);

    assign bus.full     = full_w;
    assign bus.empty    = empty_w;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;

    assign tx  = tx_q;
    assign bsy = (state_q != S_IDLE) || !empty_w;

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.wr_data;
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
            if (bus.wr_en && full_w) overflow_q <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state, FIFO pop and the line level for the current state.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        line_lvl = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (!empty_w) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                line_lvl = 1'b0;
                if (bit_done) state_d = S_DATA;
            end
            S_DATA: begin
                line_lvl = shift_q[0];
                if (bit_done && last_data)
                    state_d = (ParityMode != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                line_lvl = parity_q;
                if (bit_done) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_done && last_stop) begin
                    if (!empty_w) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bit timer, bit index, character shift register and registered line.
    // tx trails the FSM by one cycle, which is why the start bit appears two
    // cycles after the write that triggered it.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= BitReload;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            tx_q <= line_lvl;

            if (pop || bit_done || state_q == S_IDLE) bit_cnt_q <= BitReload;
            else                                      bit_cnt_q <= bit_cnt_q - 1'b1;

            if (pop) begin
                shift_q  <= head;
                parity_q <= (ParityMode == 1) ? ~(^head) : ^head;
            end else if (state_q == S_DATA && bit_done) begin
                shift_q <= shift_q >> 1;
            end

            if (bit_done && state_q == S_DATA)
                bit_idx_q <= last_data ? 4'd0 : bit_idx_q + 1'b1;
            else if (bit_done && state_q == S_STOP)
                bit_idx_q <= last_stop ? 4'd0 : bit_idx_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_uarttx_fifo.sv
// Directed bench for uarttx_fifo: four instances with BIT_TIME=16 covering
// 8N1 with a 4-deep FIFO, even and odd parity, and 5-bit data with 2 stops.
module tb_uarttx_fifo;
    localparam int BT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx0, tx1, tx2, tx3;
    logic bsy0, bsy1, bsy2, bsy3;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    uarttx_fifo_if #(.DataBits(8), .FifoDepth(4)) bus0 ();
    uarttx_fifo_if #(.DataBits(8), .FifoDepth(4)) bus1 ();
    uarttx_fifo_if #(.DataBits(8), .FifoDepth(4)) bus2 ();
    uarttx_fifo_if #(.DataBits(5), .FifoDepth(4)) bus3 ();

    uarttx_fifo #(.ClockFrequencyHz(16), .BaudRate(1), .DataBits(8), .ParityMode(0),
                  .StopBits(1), .FifoDepth(4))
        dut0 (.clk(clk), .rst(rst), .bus(bus0), .tx(tx0), .bsy(bsy0));
    uarttx_fifo #(.ClockFrequencyHz(16), .BaudRate(1), .DataBits(8), .ParityMode(2),
                  .StopBits(1), .FifoDepth(4))
        dut1 (.clk(clk), .rst(rst), .bus(bus1), .tx(tx1), .bsy(bsy1));
    uarttx_fifo #(.ClockFrequencyHz(16), .BaudRate(1), .DataBits(8), .ParityMode(1),
                  .StopBits(1), .FifoDepth(4))
        dut2 (.clk(clk), .rst(rst), .bus(bus2), .tx(tx2), .bsy(bsy2));
    uarttx_fifo #(.ClockFrequencyHz(16), .BaudRate(1), .DataBits(5), .ParityMode(0),
                  .StopBits(2), .FifoDepth(4))
        dut3 (.clk(clk), .rst(rst), .bus(bus3), .tx(tx3), .bsy(bsy3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic tx_sel(input int d);
        case (d)
            0:       return tx0;
            1:       return tx1;
            2:       return tx2;
            default: return tx3;
        endcase
    endfunction

    // Samples nbits line bits of BT cycles each, starting at the current
    // cycle; bad counts cycles that differ from the first cycle of their bit.
    task automatic capture(input int d, input int nbits,
                           output logic [127:0] bits, output int bad);
        logic s;
        bits = '0;
        bad  = 0;
        for (int i = 0; i < nbits; i++) begin
            for (int j = 0; j < BT; j++) begin
                s = tx_sel(d);
                if (j == 0) bits[i] = s;
                else if (s !== bits[i]) bad++;
                tick();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (tx0 !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx0); end
        checks++; if (bsy0 !== 1'b0) begin failures++; $display("FAIL reset_bsy got=%b exp=0", bsy0); end
        checks++; if (bus0.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", bus0.empty); end
        checks++; if (bus0.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus0.full); end
        checks++; if (bus0.count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus0.count); end
        checks++; if (bus0.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus0.overflow); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        logic [127:0] bits, exp;
        int bad;
        bus0.wr_data = 8'h55; bus0.wr_en = 1'b1;
        tick();                                   // edge 0
        bus0.wr_en = 1'b0;
        checks++; if (bus0.empty !== 1'b0) begin failures++; $display("FAIL wr_empty got=%b exp=0", bus0.empty); end
        checks++; if (bus0.count !== 3'd1) begin failures++; $display("FAIL wr_count got=%0d exp=1", bus0.count); end
        tick();                                   // edge 1: pop
        checks++; if (bus0.count !== 3'd0) begin failures++; $display("FAIL pop_count got=%0d exp=0", bus0.count); end
        checks++; if (tx0 !== 1'b1) begin failures++; $display("FAIL pre_start_tx got=%b exp=1", tx0); end
        checks++; if (bsy0 !== 1'b1) begin failures++; $display("FAIL busy_frame got=%b exp=1", bsy0); end
        tick();                                   // edge 2: start bit on line
        capture(0, 10, bits, bad);
        exp = '0;
        exp[9:0] = {1'b1, 8'h55, 1'b0};
        checks++; if (bits !== exp) begin failures++; $display("FAIL frame_55 got=%h exp=%h", bits, exp); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL frame_55_stable got=%0d exp=0", bad); end
        checks++; if (bsy0 !== 1'b0) begin failures++; $display("FAIL frame_55_bsy_end got=%b exp=0", bsy0); end
        checks++; if (tx0 !== 1'b1) begin failures++; $display("FAIL frame_55_tx_end got=%b exp=1", tx0); end
    endtask

    task automatic test_overflow();
        logic [7:0]   ch [6] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
        int           exp_cnt [6] = '{1, 1, 2, 3, 4, 4};
        logic [127:0] bits, exp;
        int           bad;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    bus0.wr_data = ch[k]; bus0.wr_en = 1'b1;
                    tick();
                    checks++;
                    if (bus0.count !== 3'(exp_cnt[k])) begin
                        failures++; $display("FAIL ovf_count_e%0d got=%0d exp=%0d", k, bus0.count, exp_cnt[k]);
                    end
                    if (k == 4) begin
                        checks++; if (bus0.full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", bus0.full); end
                        checks++; if (bus0.overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", bus0.overflow); end
                    end
                end
                bus0.wr_en = 1'b0;
                checks++; if (bus0.overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", bus0.overflow); end
            end
            begin
                repeat (3) tick();
                capture(0, 50, bits, bad);
            end
        join
        exp = '0;
        for (int k = 0; k < 5; k++) exp[k*10 +: 10] = {1'b1, ch[k], 1'b0};
        checks++; if (bits !== exp) begin failures++; $display("FAIL ovf_frames got=%h exp=%h", bits, exp); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL ovf_frames_stable got=%0d exp=0", bad); end
        checks++; if (bsy0 !== 1'b0) begin failures++; $display("FAIL ovf_bsy_end got=%b exp=0", bsy0); end
        checks++; if (bus0.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", bus0.overflow); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]   ch [7] = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h81, 8'h7E, 8'h5A};
        logic [127:0] bits, exp;
        int           bad;
        fork
            begin
                bus0.wr_data = ch[0]; bus0.wr_en = 1'b1;
                tick();                           // edge 0
                bus0.wr_en = 1'b0;
                tick();                           // edge 1: pop ch0
                bus0.wr_data = ch[1]; bus0.wr_en = 1'b1;
                tick();                           // edge 2
                bus0.wr_en = 1'b0;
                checks++; if (bus0.count !== 3'd1) begin failures++; $display("FAIL b2b_queued got=%0d exp=1", bus0.count); end
                for (int k = 1; k <= 5; k++) begin
                    repeat (158) tick();
                    bus0.wr_data = ch[k+1]; bus0.wr_en = 1'b1;
                    tick();                       // edge 160k+1: pop and write together
                    bus0.wr_en = 1'b0;
                    checks++; if (bus0.count !== 3'd1) begin failures++; $display("FAIL b2b_popwr_%0d got=%0d exp=1", k, bus0.count); end
                    tick();
                    checks++; if (bus0.count !== 3'd1) begin failures++; $display("FAIL b2b_hold_%0d got=%0d exp=1", k, bus0.count); end
                end
            end
            begin
                repeat (3) tick();
                capture(0, 70, bits, bad);
            end
        join
        exp = '0;
        for (int k = 0; k < 7; k++) exp[k*10 +: 10] = {1'b1, ch[k], 1'b0};
        checks++; if (bits !== exp) begin failures++; $display("FAIL b2b_frames got=%h exp=%h", bits, exp); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_stable got=%0d exp=0", bad); end
        checks++; if (bsy0 !== 1'b0) begin failures++; $display("FAIL b2b_bsy_end got=%b exp=0", bsy0); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] ch [4] = '{8'h00, 8'h11, 8'h22, 8'h33};
        int quiet_bad;
        for (int k = 0; k < 4; k++) begin
            bus0.wr_data = ch[k]; bus0.wr_en = 1'b1;
            tick();
        end
        bus0.wr_en = 1'b0;
        repeat (36) tick();                       // now after edge 39, inside data bit 1
        checks++; if (tx0 !== 1'b0) begin failures++; $display("FAIL mid_tx_before got=%b exp=0", tx0); end
        checks++; if (bus0.count !== 3'd3) begin failures++; $display("FAIL mid_count_before got=%0d exp=3", bus0.count); end
        rst = 1'b1;
        tick();
        checks++; if (tx0 !== 1'b1) begin failures++; $display("FAIL mid_rst_tx got=%b exp=1", tx0); end
        checks++; if (bus0.empty !== 1'b1) begin failures++; $display("FAIL mid_rst_empty got=%b exp=1", bus0.empty); end
        checks++; if (bus0.count !== 3'd0) begin failures++; $display("FAIL mid_rst_count got=%0d exp=0", bus0.count); end
        checks++; if (bsy0 !== 1'b0) begin failures++; $display("FAIL mid_rst_bsy got=%b exp=0", bsy0); end
        checks++; if (bus0.overflow !== 1'b0) begin failures++; $display("FAIL mid_rst_overflow got=%b exp=0", bus0.overflow); end
        rst = 1'b0;
        quiet_bad = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (tx0 !== 1'b1 || bsy0 !== 1'b0 || bus0.empty !== 1'b1) quiet_bad++;
        end
        checks++; if (quiet_bad !== 0) begin failures++; $display("FAIL mid_rst_quiet got=%0d exp=0", quiet_bad); end
    endtask

    task automatic test_idle_line();
        int idle_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (tx0 !== 1'b1 || bsy0 !== 1'b0) idle_bad++;
        end
        checks++; if (idle_bad !== 0) begin failures++; $display("FAIL idle_line got=%0d exp=0", idle_bad); end
    endtask

    task automatic test_parity();
        logic [127:0] bits, exp;
        int bad;
        bus1.wr_data = 8'h07; bus1.wr_en = 1'b1;
        tick();
        bus1.wr_en = 1'b0;
        repeat (2) tick();
        capture(1, 11, bits, bad);
        exp = '0;
        exp[10:0] = {1'b1, 1'b1, 8'h07, 1'b0};
        checks++; if (bits[9] !== 1'b1) begin failures++; $display("FAIL even_parity_bit got=%b exp=1", bits[9]); end
        checks++; if (bits !== exp || bad !== 0) begin failures++; $display("FAIL even_frame got=%h bad=%0d exp=%h", bits, bad, exp); end
        checks++; if (bsy1 !== 1'b0) begin failures++; $display("FAIL even_bsy_end got=%b exp=0", bsy1); end

        bus2.wr_data = 8'h07; bus2.wr_en = 1'b1;
        tick();
        bus2.wr_en = 1'b0;
        repeat (2) tick();
        capture(2, 11, bits, bad);
        exp = '0;
        exp[10:0] = {1'b1, 1'b0, 8'h07, 1'b0};
        checks++; if (bits[9] !== 1'b0) begin failures++; $display("FAIL odd_parity_bit got=%b exp=0", bits[9]); end
        checks++; if (bits !== exp || bad !== 0) begin failures++; $display("FAIL odd_frame got=%h bad=%0d exp=%h", bits, bad, exp); end
        checks++; if (bsy2 !== 1'b0) begin failures++; $display("FAIL odd_bsy_end got=%b exp=0", bsy2); end
    endtask

    task automatic test_five_bits_two_stops();
        logic [127:0] bits, exp;
        int bad;
        bus3.wr_data = 5'h1F; bus3.wr_en = 1'b1;
        tick();
        bus3.wr_en = 1'b0;
        repeat (2) tick();
        checks++; if (tx3 !== 1'b0) begin failures++; $display("FAIL d5_start got=%b exp=0", tx3); end
        capture(3, 7, bits, bad);                 // start + 5 data + first stop
        checks++; if (bsy3 !== 1'b1) begin failures++; $display("FAIL d5_bsy_stop2 got=%b exp=1", bsy3); end
        repeat (BT - 2) tick();
        checks++; if (bsy3 !== 1'b1) begin failures++; $display("FAIL d5_bsy_late got=%b exp=1", bsy3); end
        repeat (2) tick();                        // 128 cycles after the start bit began
        exp = '0;
        exp[6:0] = {1'b1, 5'h1F, 1'b0};
        checks++; if (bits !== exp || bad !== 0) begin failures++; $display("FAIL d5_frame got=%h bad=%0d exp=%h", bits, bad, exp); end
        checks++; if (bsy3 !== 1'b0 || tx3 !== 1'b1) begin failures++; $display("FAIL d5_end got bsy=%b tx=%b exp bsy=0 tx=1", bsy3, tx3); end
    endtask

    initial begin
        bus0.wr_en = 1'b0; bus0.wr_data = '0;
        bus1.wr_en = 1'b0; bus1.wr_data = '0;
        bus2.wr_en = 1'b0; bus2.wr_data = '0;
        bus3.wr_en = 1'b0; bus3.wr_data = '0;
        test_reset();
        test_single_frame();
        test_overflow();
        test_back_to_back();
        test_reset_mid_frame();
        test_idle_line();
        test_parity();
        test_five_bits_two_stops();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
